// File: rtl/sd_dat_tx_pkg.sv
// Shared definitions for the SD single-line data-block transmitter.
package sd_dat_tx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_END,
        ST_WAIT_ST,
        ST_STATUS,
        ST_BUSY,
        ST_DONE
    } state_e;

    // Card CRC status token meaning "data accepted".
    localparam logic [2:0] STATUS_OK = 3'b010;
    // Token reported when the card never answered.
    localparam logic [2:0] STATUS_TMO = 3'b111;

    // CRC-16 polynomial x^16 + x^12 + x^5 + 1.
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // One serial step of the CRC-16 register for a single data bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_dat_tx_crc16.sv
// Serial CRC-16 generator: accumulates in data mode, shifts the result out MSB-first in unload mode.
module sd_dat_tx_crc16
    import sd_dat_tx_pkg::*;
(
    input  logic iclk,
    input  logic irst,
    input  logic ien,
    input  logic iunload,
    input  logic idin,
    output logic omsb
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Next CRC value: hold, accumulate one bit, or shift towards the output.
    always_comb begin
        crc_d = crc_q;
        if (ien) begin
            if (iunload) begin
                crc_d = {crc_q[14:0], 1'b0};
            end else begin
                crc_d = crc16_step(crc_q, idin);
            end
        end
    end

    // CRC register with synchronous clear.
    always_ff @(posedge iclk) begin
        if (irst) begin
            crc_q <= 16'h0000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign omsb = crc_q[15];

endmodule

// File: rtl/sd_dat_tx.sv
// SD DAT0 block transmitter: start bit, payload, CRC-16, end bit, then CRC status and busy wait.
module sd_dat_tx
    import sd_dat_tx_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES    = 512,
    parameter int unsigned STATUS_TIMEOUT = 64,
    parameter int unsigned BUSY_TIMEOUT   = 65535
) (
    input  logic                           iclk,
    input  logic                           irst,
    input  logic                           istart,
    output logic [$clog2(BLOCK_BYTES)-1:0] oaddr,
    input  logic [7:0]                     idata,
    input  logic                           idat,
    output logic                           odat,
    output logic                           odat_oe,
    output logic                           obusy,
    output logic                           odone,
    output logic [2:0]                     ostatus,
    output logic                           oerr
);

    localparam int unsigned AW      = $clog2(BLOCK_BYTES);
    localparam int unsigned BW      = $clog2(BLOCK_BYTES * 8);
    localparam int unsigned TMO_MAX = (BUSY_TIMEOUT > STATUS_TIMEOUT) ? BUSY_TIMEOUT : STATUS_TIMEOUT;
    localparam int unsigned TW      = $clog2(TMO_MAX + 1);

    state_e        state_q,   state_d;
    logic          odat_q,    odat_d;
    logic          oe_q,      oe_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic [2:0]    status_q,  status_d;
    logic          err_q,     err_d;
    logic [7:0]    shift_q,   shift_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic crc_en;
    logic crc_unload;
    logic crc_msb;
    logic crc_rst;

    // The CRC restarts at every block so a block aborted by reset leaves no residue.
    assign crc_rst = irst | (state_q == ST_START);

    sd_dat_tx_crc16 u_crc16 (
        .iclk    (iclk),
        .irst    (crc_rst),
        .ien     (crc_en),
        .iunload (crc_unload),
        .idin    (shift_q[7]),
        .omsb    (crc_msb)
    );

    // Frame sequencing, buffer addressing and card response handling.
    always_comb begin
        state_d    = state_q;
        odat_d     = odat_q;
        oe_d       = oe_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        status_d   = status_q;
        err_d      = err_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        crc_en     = 1'b0;
        crc_unload = 1'b0;

        case (state_q)
            ST_IDLE: begin
                odat_d = 1'b1;
                oe_d   = 1'b0;
                addr_d = '0;
                if (istart) begin
                    state_d  = ST_START;
                    busy_d   = 1'b1;
                    status_d = 3'b000;
                    err_d    = 1'b0;
                end
            end
            ST_START: begin
                odat_d    = 1'b0;
                oe_d      = 1'b1;
                shift_d   = idata;
                addr_d    = AW'(1);
                bit_cnt_d = '0;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                odat_d = shift_q[7];
                crc_en = 1'b1;
                if (bit_cnt_q[2:0] == 3'd7) begin
                    // Next byte has been on idata since the cycle after its address was issued.
                    shift_d = idata;
                    if (addr_q != AW'(BLOCK_BYTES - 1)) begin
                        addr_d = addr_q + AW'(1);
                    end
                end else begin
                    shift_d = {shift_q[6:0], 1'b0};
                end
                if (bit_cnt_q == BW'(BLOCK_BYTES * 8 - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = ST_CRC;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            ST_CRC: begin
                odat_d     = crc_msb;
                crc_en     = 1'b1;
                crc_unload = 1'b1;
                if (bit_cnt_q == BW'(15)) begin
                    state_d = ST_END;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            ST_END: begin
                odat_d    = 1'b1;
                addr_d    = '0;
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_ST;
            end
            ST_WAIT_ST: begin
                odat_d = 1'b1;
                oe_d   = 1'b0;
                if (!idat) begin
                    bit_cnt_d = '0;
                    state_d   = ST_STATUS;
                end else if (tmo_cnt_q == TW'(STATUS_TIMEOUT)) begin
                    status_d = STATUS_TMO;
                    err_d    = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            ST_STATUS: begin
                if (bit_cnt_q == BW'(3)) begin
                    // This cycle carries the token end bit, which is not stored.
                    err_d     = (status_q != STATUS_OK);
                    tmo_cnt_d = '0;
                    state_d   = ST_BUSY;
                end else begin
                    status_d  = {status_q[1:0], idat};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            ST_BUSY: begin
                if (idat) begin
                    state_d = ST_DONE;
                end else if (tmo_cnt_q == TW'(BUSY_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q   <= ST_IDLE;
            odat_q    <= 1'b1;
            oe_q      <= 1'b0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            status_q  <= 3'b000;
            err_q     <= 1'b0;
            shift_q   <= 8'h00;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            odat_q    <= odat_d;
            oe_q      <= oe_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            status_q  <= status_d;
            err_q     <= err_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign odat    = odat_q;
    assign odat_oe = oe_q;
    assign oaddr   = addr_q;
    assign obusy   = busy_q;
    assign odone   = done_q;
    assign ostatus = status_q;
    assign oerr    = err_q;

endmodule

// File: tb/tb_sd_dat_tx.sv
// Scoreboard bench for sd_dat_tx: buffer RAM model, card response model, frame and completion checks.
module tb_sd_dat_tx;

    localparam int unsigned BB = 512;
    localparam int unsigned ST = 64;
    localparam int unsigned BT = 65535;
    localparam int unsigned END_CYC = 18 + 8 * BB;

    logic       iclk = 1'b0;
    logic       irst;
    logic       istart;
    logic [8:0] oaddr;
    logic [7:0] idata;
    logic       idat;
    logic       odat;
    logic       odat_oe;
    logic       obusy;
    logic       odone;
    logic [2:0] ostatus;
    logic       oerr;

    sd_dat_tx #(
        .BLOCK_BYTES    (BB),
        .STATUS_TIMEOUT (ST),
        .BUSY_TIMEOUT   (BT)
    ) dut (
        .iclk    (iclk),
        .irst    (irst),
        .istart  (istart),
        .oaddr   (oaddr),
        .idata   (idata),
        .idat    (idat),
        .odat    (odat),
        .odat_oe (odat_oe),
        .obusy   (obusy),
        .odone   (odone),
        .ostatus (ostatus),
        .oerr    (oerr)
    );

    always #5 iclk = ~iclk;

    // Zero-wait synchronous buffer RAM.
    logic [7:0] mem [BB];
    always @(posedge iclk) idata <= mem[oaddr];

    typedef struct {
        int         done_cyc;
        logic [2:0] status;
        logic       err;
    } res_t;

    logic [15:0] exp_q [$];
    res_t        res_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
        cyc++;
    endtask

    // Byte-wise reference CRC-16/XMODEM over the buffer contents.
    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        c = 16'h0000;
        for (int b = 0; b < BB; b++) begin
            c = c ^ {mem[b], 8'h00};
            for (int k = 0; k < 8; k++) begin
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic fill(input int mode);
        for (int b = 0; b < BB; b++) begin
            case (mode)
                0:       mem[b] = 8'h00;
                1:       mem[b] = 8'hFF;
                default: mem[b] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    // Send one block and play the card side; poke pulses istart during DATA and BUSY.
    task automatic run_block(input logic [15:0] exp_crc, input logic [2:0] card_st,
                             input int delay, input int busy_n, input bit silent, input bit poke);
        res_t        r;
        logic [7:0]  acc;
        logic [15:0] e;
        logic [15:0] c;
        logic        oe_ok;
        bit          seq [$];
        bit          done;

        for (int b = 0; b < BB; b++) exp_q.push_back({8'h00, mem[b]});
        exp_q.push_back(exp_crc);
        if (silent) begin
            r.done_cyc = int'(END_CYC) + 1 + int'(ST) + 1;
            r.status   = 3'b111;
            r.err      = 1'b1;
        end else begin
            r.done_cyc = int'(END_CYC) + 1 + delay + 1 + 3 + 1 + busy_n + 1 + 1;
            r.status   = card_st;
            r.err      = (card_st != 3'b010);
        end
        res_q.push_back(r);

        istart = 1'b1;
        tick();
        cyc    = 0;
        istart = 1'b0;
        chk("busy_on_accept", 32'(obusy), 32'd1);
        tick();
        chk("start_bit", 32'({odat_oe, odat}), 32'b10);

        oe_ok = 1'b1;
        for (int b = 0; b < BB; b++) begin
            acc = 8'h00;
            for (int k = 0; k < 8; k++) begin
                if (poke && b == 50 && k == 3) istart = 1'b1;
                tick();
                istart = 1'b0;
                acc    = {acc[6:0], odat};
                oe_ok  = oe_ok & odat_oe;
            end
            e = exp_q.pop_front();
            chk($sformatf("byte%0d", b), 32'(acc), 32'(e[7:0]));
        end

        c = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            tick();
            c     = {c[14:0], odat};
            oe_ok = oe_ok & odat_oe;
        end
        e = exp_q.pop_front();
        chk("crc", 32'(c), 32'(e));
        chk("oe_during_frame", 32'(oe_ok), 32'd1);

        tick();
        chk("end_bit", 32'({odat_oe, odat}), 32'b11);
        tick();
        chk("oe_fall", 32'({odat_oe, odat}), 32'b01);

        if (!silent) begin
            for (int i = 0; i < delay; i++) seq.push_back(1'b1);
            seq.push_back(1'b0);
            seq.push_back(card_st[2]);
            seq.push_back(card_st[1]);
            seq.push_back(card_st[0]);
            seq.push_back(1'b1);
            for (int i = 0; i < busy_n; i++) seq.push_back(1'b0);
        end

        done = 1'b0;
        for (int j = 0; j < 400 && !done; j++) begin
            idat = (j < seq.size()) ? seq[j] : 1'b1;
            if (poke && j == delay + 8) istart = 1'b1;
            tick();
            istart = 1'b0;
            if (odone) done = 1'b1;
        end
        idat = 1'b1;

        r = res_q.pop_front();
        chk("done_seen", 32'(done), 32'd1);
        chk("done_cycle", 32'(cyc), 32'(r.done_cyc));
        chk("status", 32'(ostatus), 32'(r.status));
        chk("err", 32'(oerr), 32'(r.err));
        chk("busy_clear", 32'(obusy), 32'd0);
        tick();
        chk("done_one_cycle", 32'(odone), 32'd0);
        chk("status_hold", 32'(ostatus), 32'(r.status));
        chk("err_hold", 32'(oerr), 32'(r.err));
    endtask

    initial begin
        irst   = 1'b1;
        istart = 1'b0;
        idat   = 1'b1;
        fill(0);
        repeat (3) tick();
        chk("rst_odat", 32'(odat), 32'd1);
        chk("rst_oe", 32'(odat_oe), 32'd0);
        chk("rst_addr", 32'(oaddr), 32'd0);
        chk("rst_flags", 32'({obusy, odone, oerr}), 32'd0);
        chk("rst_status", 32'(ostatus), 32'd0);
        irst = 1'b0;
        tick();

        fill(0);
        run_block(16'h0000, 3'b010, 2, 10, 1'b0, 1'b0);

        fill(1);
        run_block(16'h7FA1, 3'b010, 3, 5, 1'b0, 1'b0);

        fill(2);
        run_block(model_crc(), 3'b101, 1, 4, 1'b0, 1'b0);

        fill(2);
        run_block(model_crc(), 3'b000, 0, 0, 1'b1, 1'b0);

        // Abort mid-block with reset, then a clean block must follow.
        fill(2);
        istart = 1'b1;
        tick();
        istart = 1'b0;
        for (int i = 0; i < 1 + 100 * 8 + 3; i++) tick();
        chk("pre_rst_oe", 32'(odat_oe), 32'd1);
        irst = 1'b1;
        tick();
        irst = 1'b0;
        chk("mid_rst_line", 32'({odat, odat_oe}), 32'b10);
        chk("mid_rst_busy", 32'(obusy), 32'd0);
        chk("mid_rst_addr", 32'(oaddr), 32'd0);
        chk("mid_rst_done", 32'(odone), 32'd0);
        tick();
        fill(2);
        run_block(model_crc(), 3'b010, 2, 10, 1'b0, 1'b0);

        fill(2);
        run_block(model_crc(), 3'b010, 2, 10, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
